// File: rtl/nf_ram_pkg.sv
//------------------------------------------------------------------------------
// Module      : nf_ram_pkg
// Description : Shared types, constants and helpers for the byte-write data RAM.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package nf_ram_pkg;

    localparam int NF_DATA_W         = 32;
    localparam int NF_BYTES_PER_WORD = NF_DATA_W / 8;

    // One handshake pipeline stage: an accepted access, its direction and range status
    typedef struct packed {
        logic valid;
        logic we;
        logic err;
    } nf_stage_t;

    function automatic int nf_idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/nf_ram_bw_if.sv
//------------------------------------------------------------------------------
// Module      : nf_ram_bw_if
// Description : Request/acknowledge bus between the LSU-side master and the RAM.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface nf_ram_bw_if
    import nf_ram_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = NF_DATA_W
);
    logic                  req;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W/8-1:0]   be;
    logic [DATA_W-1:0]     wd;
    logic [DATA_W-1:0]     rd;
    logic                  rd_valid;
    logic                  ack;
    logic                  err;

    modport master (
        output req, we, addr, be, wd,
        input  rd, rd_valid, ack, err
    );

    modport slave (
        input  req, we, addr, be, wd,
        output rd, rd_valid, ack, err
    );
endinterface

`default_nettype wire

// File: rtl/nf_ram_bw_bank.sv
//------------------------------------------------------------------------------
// Module      : nf_ram_bw_bank
// Description : Storage array with byte-enabled synchronous write and registered read.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module nf_ram_bw_bank
    import nf_ram_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int DATA_W = NF_DATA_W,
    parameter int IDX_W  = nf_idx_w(DEPTH)
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                wr_en_i,
    input  wire logic [DATA_W/8-1:0] be_i,
    input  wire logic [IDX_W-1:0]    idx_i,
    input  wire logic [DATA_W-1:0]   wd_i,
    input  wire logic                rd_en_i,
    input  wire logic                rd_clr_i,
    output logic      [DATA_W-1:0]   rd_o
);
    localparam int BPW = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_q;

    // Contents are deliberately never reset so the array maps onto block RAM
    always_ff @(posedge clk) begin
        for (int i = 0; i < BPW; i++) begin
            if (wr_en_i && be_i[i]) begin
                mem_q[idx_i][i*8 +: 8] <= wd_i[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else if (rd_clr_i) begin
            rd_q <= '0;
        end else if (rd_en_i) begin
            rd_q <= mem_q[idx_i];
        end
    end

    assign rd_o = rd_q;

endmodule

`default_nettype wire

// File: rtl/nf_ram_bw.sv
//------------------------------------------------------------------------------
// Module      : nf_ram_bw
// Description : Single-port byte-write data RAM with registered read and ack handshake.
//               Define NF_RAM_OUT_REG_EN to add an output register (latency 2).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module nf_ram_bw
    import nf_ram_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int DATA_W = NF_DATA_W,
    parameter int ADDR_W = 32
) (
    input  wire logic    clk,
    input  wire logic    rst,
    nf_ram_bw_if.slave   bus
);
    localparam int BPW   = DATA_W / 8;
    localparam int OFF_W = (BPW > 1) ? $clog2(BPW) : 0;
    localparam int IDX_W = nf_idx_w(DEPTH);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH * BPW);

    logic              oor_w;
    logic [IDX_W-1:0]  idx_w;
    logic              wr_en_w;
    logic              rd_en_w;
    logic              rd_clr_w;
    logic [DATA_W-1:0] bank_rd_w;
    nf_stage_t         st1_d;
    nf_stage_t         st1_q;

    assign oor_w = ({1'b0, bus.addr} >= LIMIT);
    assign idx_w = bus.addr[IDX_W+OFF_W-1:OFF_W];

    // A write coinciding with reset is dropped; out-of-range reads return zero
    assign wr_en_w  = bus.req &  bus.we & ~oor_w & ~rst;
    assign rd_en_w  = bus.req & ~bus.we & ~rst;
    assign rd_clr_w = bus.req & ~bus.we & oor_w;

    always_comb begin
        st1_d       = '0;
        st1_d.valid = bus.req;
        st1_d.we    = bus.req & bus.we;
        st1_d.err   = bus.req & oor_w;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st1_q <= '0;
        end else begin
            st1_q <= st1_d;
        end
    end

    nf_ram_bw_bank #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .wr_en_i  (wr_en_w),
        .be_i     (bus.be),
        .idx_i    (idx_w),
        .wd_i     (bus.wd),
        .rd_en_i  (rd_en_w),
        .rd_clr_i (rd_clr_w),
        .rd_o     (bank_rd_w)
    );

`ifdef NF_RAM_OUT_REG_EN
    nf_stage_t         st2_q;
    logic [DATA_W-1:0] rd2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            st2_q <= '0;
            rd2_q <= '0;
        end else begin
            st2_q <= st1_q;
            if (st1_q.valid && !st1_q.we) begin
                rd2_q <= bank_rd_w;
            end
        end
    end

    assign bus.ack      = st2_q.valid;
    assign bus.rd_valid = st2_q.valid & ~st2_q.we;
    assign bus.err      = st2_q.valid & st2_q.err;
    assign bus.rd       = rd2_q;
`else
    assign bus.ack      = st1_q.valid;
    assign bus.rd_valid = st1_q.valid & ~st1_q.we;
    assign bus.err      = st1_q.valid & st1_q.err;
    assign bus.rd       = bank_rd_w;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nf_ram_bw.sv
//------------------------------------------------------------------------------
// Module      : tb_nf_ram_bw
// Description : Directed self-checking bench for nf_ram_bw (depth 256, 32-bit).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_nf_ram_bw;

`ifdef NF_RAM_OUT_REG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    typedef struct packed {
        logic        ack;
        logic        rv;
        logic        err;
        logic [31:0] rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks   = 0;
    int          failures = 0;
    exp_t        pipe [L];
    logic [31:0] last_rd = 32'h0;

    always #5 clk = ~clk;

    nf_ram_bw_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    nf_ram_bw #(
        .DEPTH  (256),
        .DATA_W (32),
        .ADDR_W (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: drive an access, advance the expected-response pipe, compare
    task automatic cyc(input logic r, input logic q, input logic w,
                       input logic [31:0] a, input logic [3:0] b, input logic [31:0] d,
                       input logic e_ack, input logic e_rv, input logic e_err,
                       input logic [31:0] e_rd, input string tag);
        exp_t nw;
        exp_t head;
        logic [31:0] exp_rd;
        rst      = r;
        bus.req  = q;
        bus.we   = w;
        bus.addr = a;
        bus.be   = b;
        bus.wd   = d;
        nw = '{ack: e_ack, rv: e_rv, err: e_err, rd: e_rd};
        if (r) begin
            for (int i = 0; i < L; i++) pipe[i] = '0;
            nw = '0;
            last_rd = 32'h0;
        end
        for (int i = 0; i < L - 1; i++) pipe[i] = pipe[i+1];
        pipe[L-1] = nw;
        head = pipe[0];
        exp_rd = head.rv ? head.rd : last_rd;
        last_rd = exp_rd;
        @(posedge clk);
        #1;
        check({tag, ".ack"},      {31'h0, bus.ack},      {31'h0, head.ack});
        check({tag, ".rd_valid"}, {31'h0, bus.rd_valid}, {31'h0, head.rv});
        check({tag, ".err"},      {31'h0, bus.err},      {31'h0, head.err});
        check({tag, ".rd"},       bus.rd,                exp_rd);
    endtask

    initial begin
        for (int i = 0; i < L; i++) pipe[i] = '0;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.be = '0; bus.wd = '0;

        cyc(1, 0, 0, 32'h0,   4'h0, 32'h0,        0, 0, 0, 32'h0,        "rst0");
        cyc(1, 0, 0, 32'h0,   4'h0, 32'h0,        0, 0, 0, 32'h0,        "rst1");

        cyc(0, 1, 1, 32'h000, 4'hF, 32'h0BADF00D, 1, 0, 0, 32'h0,        "wr0");
        cyc(0, 1, 1, 32'h018, 4'hF, 32'h01020304, 1, 0, 0, 32'h0,        "wr18");
        cyc(0, 1, 1, 32'h3FC, 4'hF, 32'h5A5A0FF0, 1, 0, 0, 32'h0,        "wr3fc");
        cyc(0, 1, 1, 32'h010, 4'hF, 32'hDEADBEEF, 1, 0, 0, 32'h0,        "wr10");
        cyc(0, 0, 0, 32'h0,   4'h0, 32'h0,        0, 0, 0, 32'h0,        "idle0");
        cyc(0, 1, 0, 32'h010, 4'h0, 32'h0,        1, 1, 0, 32'hDEADBEEF, "rd10");
        cyc(0, 0, 0, 32'h0,   4'h0, 32'h0,        0, 0, 0, 32'h0,        "idle1");

        // Byte offset in the address is ignored; only lane 1 is written
        cyc(0, 1, 1, 32'h012, 4'h2, 32'h11223344, 1, 0, 0, 32'h0,        "wr10_lane1");
        cyc(0, 1, 0, 32'h010, 4'h0, 32'h0,        1, 1, 0, 32'hDEAD33EF, "rd10_b");
        cyc(0, 1, 1, 32'h010, 4'h0, 32'hFFFFFFFF, 1, 0, 0, 32'h0,        "wr_be0");
        cyc(0, 1, 0, 32'h010, 4'h0, 32'h0,        1, 1, 0, 32'hDEAD33EF, "rd10_c");

        cyc(0, 1, 1, 32'h020, 4'hF, 32'hA5A5A5A5, 1, 0, 0, 32'h0,        "wr20");
        cyc(0, 1, 0, 32'h020, 4'h0, 32'h0,        1, 1, 0, 32'hA5A5A5A5, "rd20_b2b");

        // 0x400 aliases word 0 in the index bits, so a leaked write would corrupt it
        cyc(0, 1, 1, 32'h400, 4'hF, 32'h12345678, 1, 0, 1, 32'h0,        "wr_oor");
        cyc(0, 1, 0, 32'h000, 4'h0, 32'h0,        1, 1, 0, 32'h0BADF00D, "rd0");
        cyc(0, 1, 0, 32'h400, 4'h0, 32'h0,        1, 1, 1, 32'h0,        "rd_oor");
        cyc(0, 1, 0, 32'h3FC, 4'h0, 32'h0,        1, 1, 0, 32'h5A5A0FF0, "rd3fc");
        cyc(0, 0, 0, 32'h0,   4'h0, 32'h0,        0, 0, 0, 32'h0,        "idle2");
        cyc(0, 0, 0, 32'h0,   4'h0, 32'h0,        0, 0, 0, 32'h0,        "idle3");

        cyc(0, 1, 0, 32'h010, 4'h0, 32'h0,        1, 1, 0, 32'hDEAD33EF, "rs_rd10");
        cyc(1, 1, 0, 32'h014, 4'h0, 32'h0,        0, 0, 0, 32'h0,        "rs_rd14");
        cyc(0, 1, 0, 32'h018, 4'h0, 32'h0,        1, 1, 0, 32'h01020304, "rs_rd18");
        cyc(0, 0, 0, 32'h0,   4'h0, 32'h0,        0, 0, 0, 32'h0,        "idle4");
        cyc(0, 1, 0, 32'h010, 4'h0, 32'h0,        1, 1, 0, 32'hDEAD33EF, "rd10_after");
        cyc(0, 0, 0, 32'h0,   4'h0, 32'h0,        0, 0, 0, 32'h0,        "idle5");
        cyc(0, 0, 0, 32'h0,   4'h0, 32'h0,        0, 0, 0, 32'h0,        "idle6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nf_ram_bw.md
Name: nf_ram_bw

Overview:
Parametrised single-port data RAM with per-byte write enables, registered (synchronous) read and a request/acknowledge handshake. It replaces the combinational-read word RAM in the data path, so it can map onto block RAM. It sits behind the data-bus slave decoder and serves LSU accesses of byte, half-word and word width.

Parameters:
- depth, 256, number of data_w-bit words; power of two, at least 4.
- data_w, 32, word width in bits; multiple of 8.
- addr_w, 32, width of the incoming byte address.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  1  access request; one access per cycle.
- we  input  1  1 = write, 0 = read; sampled with req.
- addr  input  addr_w  byte address.
- be  input  data_w/8  byte enables for writes; ignored for reads.
- wd  input  data_w  write data, byte lanes aligned to be.
- rd  output  data_w  read data; valid while rd_valid is high.
- rd_valid  output  1  one-cycle pulse, read data present.
- ack  output  1  one-cycle pulse, access completed (read or write).
- err  output  1  one-cycle pulse with ack, address out of range.

Behaviour:
- Reset values: rd = 0, rd_valid = 0, ack = 0, err = 0. Memory contents are not reset.
- Word index is addr[log2(depth)+log2(data_w/8)-1 : log2(data_w/8)]. The low byte-offset bits are ignored; be selects the lanes.
- Out of range means addr >= depth*(data_w/8).
- No stall: req may be high every cycle. Each accepted req produces exactly one ack, L cycles later.
  - L = 1 without the optional feature, L = 2 with it.
- Write, in range: on the req edge, lane i is updated iff be[i] = 1; other lanes are unchanged. be = 0 completes with ack but changes no bytes. rd_valid stays 0; rd holds its previous value.
- Read, in range: on the req edge, the word is latched into rd. rd_valid = ack = 1 for exactly one cycle.
- Out-of-range access: the write is suppressed and ack = err = 1.
  - For a read, rd_valid = 1 and rd = 0.
- Write at cycle N followed by a read of the same address at cycle N+1 returns the newly written data; no stale data is returned.
- req = 0: ack, rd_valid and err are 0 on the following cycle. rd holds its last read value.
- rst asserted mid-operation: in-flight ack/rd_valid/err pulses are dropped. Writes already accepted before the reset edge remain in memory. A write presented in the same cycle as rst is not performed.
- Internal state: a per-stage valid/we/err pipeline of depth L, the rd register, and the memory array.

Optional Feature:
NF_RAM_OUT_REG_EN
- Defined: an extra output register follows the array read. Read latency and ack latency become 2.
  - rd, rd_valid, ack and err all move to the second stage and stay mutually aligned.
  - Back-to-back requests are still accepted every cycle.
  - Reset clears both stages.
- Undefined: latency is 1 as described above.

Decomposition:
- Package nf_ram_pkg:
  - function computing the word-index width from depth;
  - localparam for bytes per word (data_w/8);
  - typedef for the pipeline stage struct {valid, we, err}.
- Sub-module nf_ram_bw_bank: a pure storage array with a byte-enabled synchronous write and a registered read, no handshake. It is instantiated once.
- The top level nf_ram_bw holds the address decode, range check, handshake pipeline and the optional output stage.

Test Plan (depth = 256, data_w = 32):
- Write addr 0x10, wd 0xDEADBEEF, be 0xF; then read 0x10 -> ack on each access; read gives rd = 0xDEADBEEF with rd_valid after L cycles.
- Write addr 0x10, wd 0x11223344, be 0x2; read 0x10 -> rd = 0xDEAD33EF.
- Write addr 0x20, wd 0xA5A5A5A5 at cycle N; read 0x20 at N+1 -> rd = 0xA5A5A5A5; ack pulses on two consecutive cycles.
- Write addr 0x400, wd 0x12345678 (out of range); then read 0x0 -> write gives ack = err = 1; word 0 is unchanged (read 0x0 returns its prior value).
- Reads of 0x10, 0x14, 0x18 on three consecutive cycles with rst asserted on the second cycle -> only the first read's pulse appears, if it completes before the reset edge; all outputs are 0 in the cycle after rst; memory retains 0xDEAD33EF at 0x10.
- Repeat all scenarios with NF_RAM_OUT_REG_EN defined -> same data, every response delayed by exactly one extra cycle.
